// File: rtl/branch_predictor_pkg.sv
// Shared types, geometry and address helpers for the branch target buffer.
// Table geometry lives here so the IF next-PC mux splits addresses the same way.
package branch_predictor_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned ENTRIES = 16;
    localparam int unsigned CTR_W   = 2;
    localparam int unsigned IDX_W   = $clog2(ENTRIES);
    localparam int unsigned TAG_W   = XLEN - IDX_W - 2;

    // Weakly not-taken after reset, weakly taken on allocation.
    localparam logic [CTR_W-1:0] CTR_RESET = CTR_W'((1 << (CTR_W - 1)) - 1);
    localparam logic [CTR_W-1:0] CTR_ALLOC = CTR_W'(1 << (CTR_W - 1));

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  target;
        logic [CTR_W-1:0] ctr;
    } bp_entry_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [IDX_W-1:0] idx;
    } bp_addr_t;

    // Instructions are word aligned, so pc[1:0] carries no information.
    function automatic bp_addr_t bp_split(input logic [XLEN-1:0] pc);
        bp_addr_t a;
        logic     unused_lsb;
        unused_lsb = ^pc[1:0];
        a.idx      = pc[IDX_W+1:2];
        a.tag      = pc[XLEN-1:IDX_W+2];
        return a;
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// IF lookup, ID training and performance-count signals of the branch predictor.
interface branch_predictor_if
    import branch_predictor_pkg::*;
#(
    parameter int unsigned PERF_W = 32
) ();

    logic [XLEN-1:0]   pc_i;
    logic              hit_o;
    logic              pred_taken_o;
    logic [XLEN-1:0]   pred_target_o;
    logic              upd_valid_i;
    logic [XLEN-1:0]   upd_pc_i;
    logic              upd_taken_i;
    logic [XLEN-1:0]   upd_target_i;
    logic              upd_mispred_o;
    logic [PERF_W-1:0] perf_branches_o;
    logic [PERF_W-1:0] perf_mispred_o;

    modport master (
        output pc_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
        input  hit_o, pred_taken_o, pred_target_o, upd_mispred_o,
        input  perf_branches_o, perf_mispred_o
    );

    modport slave (
        input  pc_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
        output hit_o, pred_taken_o, pred_target_o, upd_mispred_o,
        output perf_branches_o, perf_mispred_o
    );

endinterface

// File: rtl/branch_predictor_sat_counter.sv
// Up/down saturating counter next-state logic, shared by all table entries.
module branch_predictor_sat_counter #(
    parameter int unsigned CTR_W = 2
) (
    input  logic [CTR_W-1:0] ctr_i,
    input  logic             inc_i,
    output logic [CTR_W-1:0] ctr_o
);

    localparam logic [CTR_W-1:0] CtrMax = '1;

    always_comb begin
        ctr_o = ctr_i;
        if (inc_i) begin
            if (ctr_i != CtrMax) ctr_o = ctr_i + CTR_W'(1);
        end else if (ctr_i != '0) begin
            ctr_o = ctr_i - CTR_W'(1);
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry direction counters: combinational IF lookup,
// trained from ID resolution, with wrap-around branch/mispredict counters.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int unsigned PERF_W = 32
) (
    input logic               clk_i,
    input logic               rst_i,
    branch_predictor_if.slave bp
);

    // Valid and counter bits are reset; tag and target storage is not.
    logic             valid_q  [ENTRIES];
    logic [CTR_W-1:0] ctr_q    [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [XLEN-1:0]  target_q [ENTRIES];

    logic              mispred_q;
    logic [PERF_W-1:0] perf_branches_q;
    logic [PERF_W-1:0] perf_mispred_q;

    bp_addr_t   lk_addr;
    bp_addr_t   up_addr;
    bp_entry_t  lk_entry;
    bp_entry_t  up_entry;
    logic       lk_hit;
    logic       up_hit;
    logic       up_pred;
    logic       up_mispred;
    logic [CTR_W-1:0] up_ctr_next;

    always_comb begin
        lk_addr  = bp_split(bp.pc_i);
        up_addr  = bp_split(bp.upd_pc_i);
        lk_entry = '{valid:  valid_q[lk_addr.idx],
                     tag:    tag_q[lk_addr.idx],
                     target: target_q[lk_addr.idx],
                     ctr:    ctr_q[lk_addr.idx]};
        up_entry = '{valid:  valid_q[up_addr.idx],
                     tag:    tag_q[up_addr.idx],
                     target: target_q[up_addr.idx],
                     ctr:    ctr_q[up_addr.idx]};
    end

    assign lk_hit = lk_entry.valid && (lk_entry.tag == lk_addr.tag);
    assign up_hit = up_entry.valid && (up_entry.tag == up_addr.tag);

    assign bp.hit_o         = lk_hit;
    assign bp.pred_taken_o  = lk_hit && lk_entry.ctr[CTR_W-1];
    assign bp.pred_target_o = lk_hit ? lk_entry.target : '0;

    // A correct-direction taken prediction still counts as wrong if it went elsewhere.
    assign up_pred    = up_hit && up_entry.ctr[CTR_W-1];
    assign up_mispred = (up_pred != bp.upd_taken_i) ||
                        (up_pred && bp.upd_taken_i && (up_entry.target != bp.upd_target_i));

    branch_predictor_sat_counter #(
        .CTR_W (CTR_W)
    ) u_sat_counter (
        .ctr_i (up_entry.ctr),
        .inc_i (bp.upd_taken_i),
        .ctr_o (up_ctr_next)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= CTR_RESET;
            end
            mispred_q       <= 1'b0;
            perf_branches_q <= '0;
            perf_mispred_q  <= '0;
        end else begin
            mispred_q <= bp.upd_valid_i && up_mispred;
            if (bp.upd_valid_i) begin
                perf_branches_q <= perf_branches_q + PERF_W'(1);
                perf_mispred_q  <= perf_mispred_q + PERF_W'(up_mispred);
                if (up_hit) begin
                    ctr_q[up_addr.idx] <= up_ctr_next;
                end else if (bp.upd_taken_i) begin
                    valid_q[up_addr.idx] <= 1'b1;
                    ctr_q[up_addr.idx]   <= CTR_ALLOC;
                end
            end
        end
    end

    // Taken resolutions either refresh a hit or allocate over any occupant.
    always_ff @(posedge clk_i) begin
        if (bp.upd_valid_i && bp.upd_taken_i) begin
            tag_q[up_addr.idx]    <= up_addr.tag;
            target_q[up_addr.idx] <= bp.upd_target_i;
        end
    end

    assign bp.upd_mispred_o   = mispred_q;
    assign bp.perf_branches_o = perf_branches_q;
    assign bp.perf_mispred_o  = perf_mispred_q;

endmodule
